dram_cmd_arbiter: RTL

//  Shares the single DFI command slot between the per-bank bank_manager instances and the

---
 rtl/dram_cmd_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_arbiter.sv
// dram_cmd_arbiter: round-robin DFI command slot arbiter with refresh priority, tRRD/tCCD spacing
// and a PREA->REF->tRFC sequence; DRAM_CMD_ARB_TFAW_EN adds the four-activate window.
module dram_cmd_arbiter #(
   parameter int C_NUM_BANKS  = 8,
   parameter int C_BANK_WIDTH = 3,
   parameter int C_ROW_WIDTH  = 16,
   parameter int C_COL_WIDTH  = 12,
   parameter int C_TRRD       = 4,
   parameter int C_TCCD       = 4,
   parameter int C_TRP        = 11,
   parameter int C_TRFC       = 128,
   parameter int C_TFAW       = 20
) (
   input  logic                               core_clk,
   input  logic                               core_arstn,
   input  logic [C_NUM_BANKS-1:0]             bm_req,
   input  logic [3*C_NUM_BANKS-1:0]           bm_cmd,
   input  logic [C_ROW_WIDTH*C_NUM_BANKS-1:0] bm_row,
   input  logic [C_COL_WIDTH*C_NUM_BANKS-1:0] bm_col,
   output logic [C_NUM_BANKS-1:0]             bm_gnt,
   input  logic                               ref_req,
   output logic                               ref_do,
   output logic                               cmd_valid,
   output logic [2:0]                         cmd_code,
   output logic [C_BANK_WIDTH-1:0]            cmd_bank,
   output logic [C_ROW_WIDTH-1:0]             cmd_addr,
   output logic                               ref_busy
);
   localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, PREA = 3'd5, REF = 3'd6;
   localparam int TRRD_W   = $clog2(C_TRRD + 1);
   localparam int TCCD_W   = $clog2(C_TCCD + 1);
   localparam int WAIT_MAX = (C_TRFC > C_TRP) ? C_TRFC : C_TRP;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {S_ARB, S_PRE, S_RFC} state_t;

   state_t                  state, state_nx;
   logic [TRRD_W-1:0]       trrd_cnt, trrd_nx;
   logic [TCCD_W-1:0]       tccd_cnt, tccd_nx;
   logic [WAIT_W-1:0]       wait_cnt, wait_nx;
   logic [C_BANK_WIDTH-1:0] rr_ptr, rr_nx, win, idx, bank_nx;
   logic [C_NUM_BANKS-1:0]  elig, gnt_nx;
   logic [C_ROW_WIDTH-1:0]  addr_nx;
   logic [2:0]              code_nx, win_cmd;
   logic                    found, act_ok, ref_do_nx;

   always_comb begin
      elig = '0;
      for (int i = 0; i < C_NUM_BANKS; i++)
         elig[i] = bm_req[i] && !bm_gnt[i] &&
                   ((bm_cmd[3*i +: 3] == ACT) ? act_ok :
                    (bm_cmd[3*i +: 3] == RD || bm_cmd[3*i +: 3] == WR) ? (tccd_cnt == '0) :
                    (bm_cmd[3*i +: 3] == PRE));
   end

   // rr_ptr holds the first bank to consider, i.e. last granted + 1
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < C_NUM_BANKS; k++) begin
         idx = C_BANK_WIDTH'((int'(rr_ptr) + k) % C_NUM_BANKS);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign win_cmd = bm_cmd[3*win +: 3];

   always_comb begin
      state_nx  = state;
      wait_nx   = (wait_cnt != '0) ? wait_cnt - 1'b1 : wait_cnt;
      code_nx   = NOP;
      bank_nx   = '0;
      addr_nx   = '0;
      gnt_nx    = '0;
      ref_do_nx = 1'b0;
      rr_nx     = rr_ptr;
      if (state == S_ARB && ref_req) begin
         code_nx  = PREA;
         addr_nx  = C_ROW_WIDTH'(1 << 10);
         wait_nx  = WAIT_W'(C_TRP - 1);
         state_nx = S_PRE;
      end else if (state == S_ARB && found) begin
         code_nx = win_cmd;
         bank_nx = win;
         gnt_nx  = C_NUM_BANKS'(1) << win;
         addr_nx = (win_cmd == ACT) ? bm_row[C_ROW_WIDTH*win +: C_ROW_WIDTH] :
                   (win_cmd == PRE) ? '0 : C_ROW_WIDTH'(bm_col[C_COL_WIDTH*win +: C_COL_WIDTH]);
         rr_nx   = C_BANK_WIDTH'((int'(win) + 1) % C_NUM_BANKS);
      end else if (state == S_PRE && wait_cnt == '0) begin
         code_nx   = REF;
         ref_do_nx = 1'b1;
         wait_nx   = WAIT_W'(C_TRFC - 1);
         state_nx  = S_RFC;
      end else if (state == S_RFC && wait_cnt == '0) begin
         state_nx = S_ARB;
      end
   end

   assign trrd_nx = (code_nx == ACT) ? TRRD_W'(C_TRRD - 1) :
                    (trrd_cnt != '0) ? trrd_cnt - 1'b1 : trrd_cnt;
   assign tccd_nx = (code_nx == RD || code_nx == WR) ? TCCD_W'(C_TCCD - 1) :
                    (tccd_cnt != '0) ? tccd_cnt - 1'b1 : tccd_cnt;

`ifdef DRAM_CMD_ARB_TFAW_EN
   localparam int FAW_W = $clog2(C_TFAW + 1);
   // ages are loaded with 1 so the slot frees exactly C_TFAW cycles after its ACT
   logic [FAW_W-1:0] faw_age [4];
   logic [1:0]       faw_wp;

   assign act_ok = (trrd_cnt == '0) && (faw_age[faw_wp] >= FAW_W'(C_TFAW));

   always_ff @(posedge core_clk or negedge core_arstn) begin
      if (!core_arstn) begin
         faw_wp <= '0;
         for (int i = 0; i < 4; i++) faw_age[i] <= FAW_W'(C_TFAW);
      end else begin
         if (code_nx == ACT) faw_wp <= faw_wp + 1'b1;
         for (int i = 0; i < 4; i++)
            faw_age[i] <= (code_nx == ACT && faw_wp == 2'(i)) ? FAW_W'(1) :
                          (faw_age[i] < FAW_W'(C_TFAW)) ? faw_age[i] + 1'b1 : faw_age[i];
      end
   end
`else
   assign act_ok = (trrd_cnt == '0);
`endif

   always_ff @(posedge core_clk or negedge core_arstn) begin
      if (!core_arstn) begin
         state     <= S_ARB;
         trrd_cnt  <= '0;
         tccd_cnt  <= '0;
         wait_cnt  <= '0;
         rr_ptr    <= '0;
         bm_gnt    <= '0;
         ref_do    <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_code  <= NOP;
         cmd_bank  <= '0;
         cmd_addr  <= '0;
         ref_busy  <= 1'b0;
      end else begin
         state     <= state_nx;
         trrd_cnt  <= trrd_nx;
         tccd_cnt  <= tccd_nx;
         wait_cnt  <= wait_nx;
         rr_ptr    <= rr_nx;
         bm_gnt    <= gnt_nx;
         ref_do    <= ref_do_nx;
         cmd_valid <= (code_nx != NOP);
         cmd_code  <= code_nx;
         cmd_bank  <= bank_nx;
         cmd_addr  <= addr_nx;
         ref_busy  <= (state_nx != S_ARB);
      end
   end
endmodule
